// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage types: PC, instruction, queue entry, halt opcode.
// Imported by if_queue and if_fetch_queue.
package if_fetch_queue_pkg;

  localparam int IF_PC_W    = 8;
  localparam int IF_INSTR_W = 32;

  typedef logic [IF_PC_W-1:0]    ProgramCounter;
  typedef logic [IF_INSTR_W-1:0] Instruction;

  typedef struct packed {
    ProgramCounter next_pc;
    Instruction    instr;
  } IF_entry;

  localparam Instruction HALT_INSTR = '1;

endpackage

// File: rtl/if_queue.sv
// Small FIFO of fetched entries with synchronous clear.
// Head entry and head-valid are registered; no write-to-read bypass.
module if_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  IF_entry                      din,
  output IF_entry                      head,
  output logic                         head_valid,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  IF_entry         mem_q [QDEPTH];
  IF_entry         mem_d [QDEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  IF_entry         head_q, head_d;
  logic            valid_q, valid_d;
  logic            push_ok, pop_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointers, count, storage and registered head.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    valid_d = valid_q;
    pop_ok  = pop & (cnt_q != '0);
    push_ok = push & ((cnt_q < CW'(QDEPTH)) | pop_ok);
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = inc(wr_q);
      end
      if (pop_ok) rd_d = inc(rd_q);
      cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
      valid_d = (cnt_d != '0);
      if (cnt_d != '0) head_d = mem_d[rd_d];
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head       = head_q;
  assign head_valid = valid_q;
  assign count      = cnt_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC, redirects, fetch queue to decode.
// Optional halt-on-all-ones fetch enabled by macro IF_HALT_EN.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                PC_W     = IF_PC_W,
  parameter int                INSTR_W  = IF_INSTR_W,
  parameter int                QDEPTH   = 2,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_W-1:0]      pc_branch,
  input  logic                 jmp,
  input  logic [PC_W-1:0]      pc_jmp,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_instr,
  output logic                 fd_valid,
  output logic [PC_W-1:0]      fd_pc,
  output logic [INSTR_W-1:0]   fd_instr,
  output logic                 flush,
  output logic                 halted
);

  localparam int CW = $clog2(QDEPTH+1);

  ProgramCounter  pc_q, pc_d;
  logic           flush_q, flush_d;
  logic           redirect;
  ProgramCounter  target;
  logic           pop, push;
  logic           halt_st;
  IF_entry        q_din, q_head;
  logic           q_valid;
  logic [CW-1:0]  q_count;

`ifdef IF_HALT_EN
  logic halted_q, halted_d;

  // Halt after pushing an all-ones word; redirect releases it.
  always_comb begin
    halted_d = halted_q;
    if (redirect)
      halted_d = 1'b0;
    else if (push && (imem_instr == HALT_INSTR))
      halted_d = 1'b1;
  end

  // Halt state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted_q <= 1'b0;
    else      halted_q <= halted_d;
  end

  assign halt_st = halted_q;
`else
  assign halt_st = 1'b0;
`endif

  // Handshake, push qualification and next PC.
  always_comb begin
    redirect = branch_taken | jmp;
    target   = branch_taken ? pc_branch : pc_jmp;
    pop      = q_valid & ~stall;
    push     = ~redirect
             & ((q_count < CW'(QDEPTH)) | pop)
             & ~halt_st;
    pc_d     = pc_q;
    if (redirect)  pc_d = target;
    else if (push) pc_d = pc_q + 1'b1;
    flush_d  = redirect;
    q_din    = '{next_pc: pc_q + 1'b1, instr: imem_instr};
  end

  // PC and flush registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  if_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect),
    .push       (push),
    .pop        (pop),
    .din        (q_din),
    .head       (q_head),
    .head_valid (q_valid),
    .count      (q_count)
  );

  assign imem_addr = pc_q;
  assign fd_valid  = q_valid;
  assign fd_pc     = q_head.next_pc;
  assign fd_instr  = q_head.instr;
  assign flush     = flush_q;
  assign halted    = halt_st;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a delivery scoreboard.
// Define IF_HALT_EN to also exercise the halt sequence.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  pc_branch;
  logic        jmp;
  logic [7:0]  pc_jmp;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        fd_valid;
  logic [7:0]  fd_pc;
  logic [31:0] fd_instr;
  logic        flush;
  logic        halted;
  logic        halt_rom;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;

  if_fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .pc_branch    (pc_branch),
    .jmp          (jmp),
    .pc_jmp       (pc_jmp),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .fd_valid     (fd_valid),
    .fd_pc        (fd_pc),
    .fd_instr     (fd_instr),
    .flush        (flush),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (halt_rom && imem_addr == 8'd3)
      imem_instr = 32'hFFFF_FFFF;
    else
      imem_instr = 32'h1000_0000 + {24'h0, imem_addr};
  end

  // Monitor: every accepted head is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst && fd_valid && !stall && !branch_taken && !jmp) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL deliver: unexpected pc=%h instr=%h", fd_pc, fd_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (fd_pc !== e.pc || fd_instr !== e.ins) begin
          n_miss++;
          $display("FAIL deliver: got pc=%h instr=%h want pc=%h instr=%h",
                   fd_pc, fd_instr, e.pc, e.ins);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic exp(input logic [7:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    pc_branch = '0;
    jmp = 1'b0;
    pc_jmp = '0;
    halt_rom = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 32'(fd_valid), 32'd0);
    chk("rst_pc", 32'(fd_pc), 32'd0);
    chk("rst_instr", fd_instr, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    chk("start_addr", 32'(imem_addr), 32'd0);
    for (int i = 1; i <= 3; i++)
      exp(8'(i), 32'h1000_0000 + 32'(i - 1));
    cyc();
    chk("first_valid", 32'(fd_valid), 32'd1);
    cyc();
    cyc();
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_pc", 32'(fd_pc), 32'd4);
      chk("stall_hold_ins", fd_instr, 32'h1000_0003);
      if (i < 4) cyc();
    end
    chk("stall_pc_stop", 32'(imem_addr), 32'd5);
    cyc();
    stall = 1'b0;
    for (int i = 4; i <= 6; i++)
      exp(8'(i), 32'h1000_0000 + 32'(i - 1));
    cyc();
    cyc();
    cyc();
    stall = 1'b1;
    branch_taken = 1'b1;
    pc_branch = 8'h40;
    cyc();
    branch_taken = 1'b0;
    stall = 1'b0;
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_valid", 32'(fd_valid), 32'd0);
    chk("br_addr", 32'(imem_addr), 32'h40);
    exp(8'h41, 32'h1000_0040);
    cyc();
    chk("br_flush_end", 32'(flush), 32'd0);
    chk("br_valid2", 32'(fd_valid), 32'd1);
    cyc();
    branch_taken = 1'b1;
    pc_branch = 8'h20;
    jmp = 1'b1;
    pc_jmp = 8'h80;
    cyc();
    branch_taken = 1'b0;
    jmp = 1'b0;
    chk("prio_addr", 32'(imem_addr), 32'h20);
    chk("prio_flush", 32'(flush), 32'd1);
    exp(8'h21, 32'h1000_0020);
    cyc();
    cyc();
    jmp = 1'b1;
    pc_jmp = 8'hFE;
    cyc();
    jmp = 1'b0;
    chk("wrap_fe", 32'(imem_addr), 32'hFE);
    exp(8'hFF, 32'h1000_00FE);
    exp(8'h00, 32'h1000_00FF);
    exp(8'h01, 32'h1000_0000);
    cyc();
    chk("wrap_ff", 32'(imem_addr), 32'hFF);
    cyc();
    chk("wrap_00", 32'(imem_addr), 32'h00);
    cyc();
    cyc();
    stall = 1'b1;
    cyc();
    cyc();
    chk("full_valid", 32'(fd_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(fd_valid), 32'd0);
    chk("arst_pc", 32'(fd_pc), 32'd0);
    chk("arst_instr", fd_instr, 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("drained_1", 32'(exp_q.size()), 32'd0);
    cyc();
    rst = 1'b1;
    stall = 1'b0;
    chk("restart_addr", 32'(imem_addr), 32'd0);
    for (int i = 1; i <= 3; i++)
      exp(8'(i), 32'h1000_0000 + 32'(i - 1));
    cyc();
    cyc();
    cyc();
    cyc();
    stall = 1'b1;
    cyc();
    chk("drained_2", 32'(exp_q.size()), 32'd0);
`ifdef IF_HALT_EN
    rst = 1'b0;
    halt_rom = 1'b1;
    cyc();
    rst = 1'b1;
    stall = 1'b0;
    exp(8'd1, 32'h1000_0000);
    exp(8'd2, 32'h1000_0001);
    exp(8'd3, 32'h1000_0002);
    exp(8'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) cyc();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_pc", 32'(imem_addr), 32'd4);
    chk("halt_empty", 32'(fd_valid), 32'd0);
    cyc();
    chk("halt_pc_hold", 32'(imem_addr), 32'd4);
    jmp = 1'b1;
    pc_jmp = 8'h10;
    cyc();
    jmp = 1'b0;
    chk("halt_clear", 32'(halted), 32'd0);
    chk("halt_resume", 32'(imem_addr), 32'h10);
    exp(8'h11, 32'h1000_0010);
    cyc();
    cyc();
    stall = 1'b1;
    cyc();
    chk("drained_3", 32'(exp_q.size()), 32'd0);
`else
    chk("no_halt", 32'(halted), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
